// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and saturation constants for addsub_seq16
package addsub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;
  localparam logic [3:0]  SAT_POS4  = 4'h7;
  localparam logic [3:0]  SAT_NEG4  = 4'h8;
endpackage

// File: rtl/addsub_seq16_cla.sv
// cla_4bit: 4-bit carry-lookahead adder slice with optional invert-b subtract and signed saturation
module cla_4bit
  import addsub_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  input  logic       sat,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] be, g, p, raw;
  logic [4:0] c;
  logic       ov;
  // lookahead carries, raw sum, and optional signed clamp on overflow
  always_comb begin
    be   = sub ? ~b : b;
    g    = a & be;
    p    = a ^ be;
    c[0] = cin | sub;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    raw  = p ^ c[3:0];
    ov   = c[4] ^ c[3];
    sum  = (sat && ov) ? (a[3] ? SAT_NEG4 : SAT_POS4) : raw;
    cout = c[4];
  end
endmodule

// File: rtl/addsub_seq16.sv
// addsub_seq16: sequences one 4-bit CLA slice over four passes for 16-bit or 4x4-bit saturating add/sub
module addsub_seq16
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         lane_mode,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovfl
);
  state_t             state;
  logic [1:0]         cnt;
  logic [W-1:0]       a_r, b_r, raw, raw_nx, lane_res, sat_res;
  logic               sub_r, lane_r, carry, ov16, sat_ov;
  logic [NIBBLES-1:0] lane_ov;
  logic [3:0]         s_a, s_b, s_sum;
  logic               s_cin, s_cout;

  cla_4bit u_cla (
    .a(s_a), .b(s_b), .cin(s_cin), .sub(1'b0), .sat(1'b0), .sum(s_sum), .cout(s_cout)
  );

  // select the current nibble; subtraction is ~B plus a carry-in of one
  always_comb begin
    s_a   = a_r[4*cnt +: 4];
    s_b   = sub_r ? ~b_r[4*cnt +: 4] : b_r[4*cnt +: 4];
    s_cin = lane_r ? sub_r : carry;
  end

  // merge this pass's nibble and saturate, so the last pass can commit the final result directly
  always_comb begin
    raw_nx = raw;
    raw_nx[4*cnt +: 4] = s_sum;
    lane_res = raw_nx;
    lane_ov = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      lane_ov[i] = (a_r[4*i+3] == (sub_r ^ b_r[4*i+3])) && (raw_nx[4*i+3] != a_r[4*i+3]);
      lane_res[4*i +: 4] = lane_ov[i] ? (a_r[4*i+3] ? SAT_NEG4 : SAT_POS4) : raw_nx[4*i +: 4];
    end
    ov16    = (a_r[W-1] == (sub_r ^ b_r[W-1])) && (raw_nx[W-1] != a_r[W-1]);
    sat_res = lane_r ? lane_res : ov16 ? (a_r[W-1] ? SAT_NEG16 : SAT_POS16) : raw_nx;
    sat_ov  = lane_r ? |lane_ov : ov16;
  end

  // control FSM with registered handshake outputs and the nibble datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovfl   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      lane_r <= 1'b0;
      raw    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
            cnt    <= '0;
            a_r    <= a;
            b_r    <= b;
            sub_r  <= sub;
            lane_r <= lane_mode;
            carry  <= sub;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          raw   <= raw_nx;
          carry <= s_cout;
          cnt   <= cnt + 2'd1;
          if (cnt == 2'(NIBBLES - 1)) begin
            state  <= DONE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= sat_res;
            ovfl   <= sat_ov;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq16.sv
// tb_addsub_seq16: directed vectors checked against an arithmetic reference model every cycle
module tb_addsub_seq16;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, lane_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ready, busy, done, ovfl;
  logic [15:0] result;
  int          checks = 0, failures = 0, cyc = 0;
  int          m_left = 0;
  logic        m_done = 1'b0, m_ov = 1'b0, p_ov = 1'b0;
  logic [15:0] m_res = '0, p_res = '0;

  addsub_seq16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .lane_mode(lane_mode), .ready(ready), .busy(busy), .done(done),
    .result(result), .ovfl(ovfl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // true signed arithmetic clamped to range: {ovfl, result}
  function automatic logic [16:0] golden(input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input logic l);
    logic [15:0]       r;
    logic              o;
    logic signed [3:0] xn, yn;
    int                xi, yi, v;
    o = 1'b0;
    r = '0;
    if (!l) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
      v  = s ? xi - yi : xi + yi;
      if (v > 32767) begin r = 16'h7FFF; o = 1'b1; end
      else if (v < -32768) begin r = 16'h8000; o = 1'b1; end
      else r = v[15:0];
    end else begin
      for (int i = 0; i < 4; i++) begin
        xn = x[4*i +: 4];
        yn = y[4*i +: 4];
        xi = xn;
        yi = yn;
        v  = s ? xi - yi : xi + yi;
        if (v > 7) begin r[4*i +: 4] = 4'h7; o = 1'b1; end
        else if (v < -8) begin r[4*i +: 4] = 4'h8; o = 1'b1; end
        else r[4*i +: 4] = v[3:0];
      end
    end
    return {o, r};
  endfunction

  // reference: an accepted request completes four cycles later; result held until the next completion
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_ov   <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_res <= p_res;
        m_ov  <= p_ov;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= 4;
        {p_ov, p_res} <= golden(a, b, sub, lane_mode);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // compare every output against the reference each cycle, away from the rising edge
  always @(negedge clk) begin
    chk("m_ready", ready, m_left == 0);
    chk("m_busy", busy, m_left != 0);
    chk("m_done", done, m_done);
    chk("m_result", result, m_res);
    chk("m_ovfl", ovfl, m_ov);
  end

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within 20 cycles at cycle %0d", cyc);
    end
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic s, input logic l,
                    input logic [15:0] er, input logic eo);
    int t0, td;
    @(negedge clk);
    a = x; b = y; sub = s; lane_mode = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    wait_done(td);
    chk("latency", td - t0, 4);
    chk("result", result, er);
    chk("ovfl", ovfl, eo);
  endtask

  initial begin
    int t0, td;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovfl", ovfl, 0);
    rst_n = 1'b1;

    op(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1);
    op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    op(16'h0000, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 1'b1);
    op(16'hFFFF, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 1'b0);
    op(16'h72F3, 16'h1191, 1'b0, 1'b1, 16'h7384, 1'b1);
    op(16'h8123, 16'h1111, 1'b1, 1'b1, 16'h8012, 1'b1);
    op(16'h1234, 16'h1111, 1'b1, 1'b1, 16'h0123, 1'b0);

    // starts during RUN are ignored; a start held through DONE is taken back-to-back
    @(negedge clk);
    a = 16'h1234; b = 16'h0F0F; sub = 1'b0; lane_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    a = 16'h1111; b = 16'h1111;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("hs_busy", busy, 1);
    end
    a = 16'h0005; b = 16'h0007; sub = 1'b1;
    @(negedge clk);
    chk("hs_done1_time", cyc - t0, 4);
    chk("hs_done1", done, 1);
    chk("hs_result1", result, 16'h2143);
    chk("hs_ovfl1", ovfl, 0);
    @(negedge clk);
    start = 1'b0;
    chk("hs_b2b_busy", busy, 1);
    wait_done(td);
    chk("hs_done2_time", td - t0, 9);
    chk("hs_result2", result, 16'hFFFE);
    chk("hs_ovfl2", ovfl, 0);

    // asynchronous reset while the third nibble is in flight
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; sub = 1'b0; lane_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ready", ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_result", result, 0);
    chk("mid_ovfl", ovfl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    op(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
